// File: rtl/keypad_digit_encoder.sv
// Keypad front end for the timer digit-load port: synchronize and debounce a
// one-hot 10-key pad, emit one BCD digit with a one-cycle active-low loadn.

module keypad_sync_bit (
   input  logic CLK,
   input  logic clear,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge CLK or posedge clear) begin
      if (clear) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

module keypad_digit_encoder #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MAX_DIGITS      = 4
) (
   input  logic       CLK,
   input  logic       clear,
   input  logic [9:0] keypad,
   input  logic       timer_busy,
   input  logic       entry_clr,
   output logic [3:0] data,
   output logic       loadn,
   output logic [2:0] digit_count,
   output logic       entry_full
);
   typedef enum logic [1:0] {IDLE, DEBOUNCE, LOAD, WAIT_RELEASE} state_t;

   localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES);
   localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

   state_t     state, state_nx;
   logic [9:0] ks, code, code_nx;
   logic [7:0] cnt, cnt_nx;
   logic       key_valid, load_fire;
   logic [2:0] count_inc;

   keypad_sync_bit u_sync [9:0] (
      .CLK   (CLK),
      .clear (clear),
      .d     (keypad),
      .q     (ks)
   );

   function automatic logic [3:0] encode(input logic [9:0] c);
      logic [3:0] v;
      v = 4'd0;
      for (int k = 0; k < 10; k++)
         if (c[k]) v = 4'(k);
      return v;
   endfunction

   assign key_valid = $onehot(ks);
   assign load_fire = (state == LOAD);
   assign count_inc = (digit_count >= MAX_CNT) ? MAX_CNT : digit_count + 3'd1;

   always_ff @(posedge CLK or posedge clear) begin
      if (clear) begin
         state <= IDLE;
         cnt   <= 8'd0;
         code  <= 10'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         code  <= code_nx;
      end
   end

   // cnt counts matching samples in DEBOUNCE and quiet samples in WAIT_RELEASE.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      code_nx  = code;
      case (state)
         IDLE: begin
            if (key_valid && !timer_busy && !entry_full) begin
               code_nx  = ks;
               cnt_nx   = 8'd1;
               state_nx = (DB_LAST == 8'd1) ? LOAD : DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (!key_valid || timer_busy) begin
               state_nx = IDLE;
            end else if (ks != code) begin
               code_nx = ks;
               cnt_nx  = 8'd1;
            end else begin
               cnt_nx = cnt + 8'd1;
               if (cnt_nx >= DB_LAST) state_nx = LOAD;
            end
         end
         LOAD: begin
            cnt_nx   = 8'd0;
            state_nx = WAIT_RELEASE;
         end
         WAIT_RELEASE: begin
            if (|ks) begin
               cnt_nx = 8'd0;
            end else if (cnt + 8'd1 >= DB_LAST) begin
               cnt_nx   = 8'd0;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + 8'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // entry_clr in the LOAD cycle swallows the digit: no strobe, data kept.
   always_ff @(posedge CLK or posedge clear) begin
      if (clear) begin
         data        <= 4'd0;
         loadn       <= 1'b1;
         digit_count <= 3'd0;
         entry_full  <= 1'b0;
      end else begin
         loadn <= !(load_fire && !entry_clr);
         if (load_fire && !entry_clr) data <= encode(code);
         if (entry_clr) begin
            digit_count <= 3'd0;
            entry_full  <= 1'b0;
         end else if (load_fire) begin
            digit_count <= count_inc;
            entry_full  <= (count_inc == MAX_CNT);
         end
      end
   end
endmodule

// File: tb/tb_keypad_digit_encoder.sv
// Bench for keypad_digit_encoder: directed plan steps plus random key episodes,
// every cycle compared with a press-level timing model.

module tb_keypad_digit_encoder;
   localparam int D   = 4;
   localparam int MAX = 4;

   logic       CLK = 1'b0;
   logic       clear = 1'b0;
   logic [9:0] keypad = 10'd0;
   logic       timer_busy = 1'b0;
   logic       entry_clr = 1'b0;
   logic [3:0] data;
   logic       loadn;
   logic [2:0] digit_count;
   logic       entry_full;

   int checks = 0;
   int failures = 0;
   int edge_no = 0;
   int exp_edge = -1;
   int abort_edge = -1;
   int exp_val = 0;
   int m_cnt = 0;
   int m_data = 0;

   keypad_digit_encoder #(.DEBOUNCE_CYCLES(D), .MAX_DIGITS(MAX)) dut (
      .CLK         (CLK),
      .clear       (clear),
      .keypad      (keypad),
      .timer_busy  (timer_busy),
      .entry_clr   (entry_clr),
      .data        (data),
      .loadn       (loadn),
      .digit_count (digit_count),
      .entry_full  (entry_full)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input logic exp_loadn);
      check("loadn", 32'(loadn), 32'(exp_loadn));
      check("data", 32'(data), 32'(m_data));
      check("digit_count", 32'(digit_count), 32'(m_cnt));
      check("entry_full", 32'(entry_full), 32'(m_cnt == MAX));
   endtask

   // Asynchronous clear while the strobe is low: outputs must drop at once.
   task automatic do_abort();
      #2 clear = 1'b1;
      #1;
      m_cnt = 0; m_data = 0; exp_edge = -1; abort_edge = -1;
      check_all(1'b1);
      @(negedge CLK);
      clear = 1'b0;
   endtask

   task automatic step(input logic [9:0] k, input logic b, input logic c);
      logic strobe;
      @(negedge CLK);
      keypad = k; timer_busy = b; entry_clr = c;
      @(posedge CLK);
      edge_no++;
      strobe = (edge_no == exp_edge);
      if (strobe && !c) begin
         m_data = exp_val;
         if (m_cnt < MAX) m_cnt++;
      end
      if (c) m_cnt = 0;
      #1;
      check_all(!(strobe && !c));
      if (edge_no == abort_edge) do_abort();
   endtask

   // A press: pat held for h sampling edges, busy high for the first bh of them,
   // then g quiet edges. Accepted when one key is seen for D edges with busy low.
   task automatic episode(input logic [9:0] pat, input int h, input int bh, input int g,
                          input bit clr_end, input bit clr_load, input bit abort);
      int e0, s;
      bit ok;
      logic c;
      e0 = edge_no + 1;
      s  = (bh > 2) ? e0 + bh : e0 + 2;
      ok = ($countones(pat) == 1) && (m_cnt < MAX) && (s + D - 1 <= e0 + h + 1);
      exp_edge = ok ? s + D : -1;
      for (int k = 0; k < 10; k++) if (pat[k]) exp_val = k;
      abort_edge = (abort && ok) ? exp_edge : -1;
      for (int i = 0; i < h; i++) begin
         c = clr_load && (edge_no + 1 == exp_edge);
         step(pat, (i < bh), c);
      end
      for (int i = 0; i < g; i++) begin
         c = (clr_end && i == g - 1) || (clr_load && (edge_no + 1 == exp_edge));
         step(10'd0, 1'b0, c);
      end
   endtask

   function automatic logic [9:0] key(input int k);
      logic [9:0] v;
      v = 10'd1;
      return v << k;
   endfunction

   initial begin
      logic [9:0] pat;
      int a, b, h, bh;

      #7 clear = 1'b1;
      #3;
      check_all(1'b1);
      #2 clear = 1'b0;

      for (int i = 0; i < 3; i++) step(10'd0, 1'b0, 1'b0);
      episode(key(7), 8, 0, D + 3, 0, 0, 0);          // single press

      for (int i = 0; i < 3; i++) episode(key(2), 2, 0, 2, 0, 0, 0); // bounce
      episode(key(2), D + 3, 0, D + 3, 1, 0, 0);      // settles; clear count after

      episode(key(2), D + 2, 0, D + 3, 0, 0, 0);      // four-digit sequence
      episode(key(1), D,     0, D + 3, 0, 0, 0);
      episode(key(7), D + 1, 0, D + 3, 0, 0, 0);
      episode(key(9), D + 4, 0, D + 3, 0, 0, 0);
      episode(key(3), D + 4, 0, D + 3, 1, 0, 0);      // full: ignored

      episode(key(1) | key(4), 8, 0, D + 3, 0, 0, 0); // two keys
      episode(key(5), 8, 8, D + 3, 0, 0, 0);          // busy throughout
      episode(key(5), 12, 5, D + 3, 0, 0, 0);         // busy drops while held
      episode(key(6), D - 1, 0, D + 3, 0, 0, 0);      // one edge too short

      episode(key(8), D + 2, 0, D + 3, 0, 0, 1);      // clear during strobe
      episode(key(4), D + 2, 0, D + 3, 0, 1, 0);      // entry_clr in LOAD
      episode(key(4), D + 2, 0, D + 3, 0, 0, 0);

      for (int n = 0; n < 30; n++) begin
         a = int'($urandom_range(0, 9));
         if ($urandom_range(0, 5) == 0) begin
            b = (a + 1 + int'($urandom_range(0, 8))) % 10;
            pat = key(a) | key(b);
         end else begin
            pat = key(a);
         end
         h  = int'($urandom_range(1, D + 6));
         bh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, h)) : 0;
         episode(pat, h, bh, int'($urandom_range(D + 2, D + 6)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
